// File: rtl/spi_ctrl_master_if.sv
// Handshake and serial-pin bundle between the SPI initiator and its user/slave.
interface spi_ctrl_master_if #(
  parameter int FRAME_BITS = 16
);
  logic                  start;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  sck;
  logic                  mosi;
  logic                  ss;
  logic                  miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sck, mosi, ss
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sck, mosi, ss
  );
endinterface

// File: rtl/spi_ctrl_master.sv
// Mode-0, MSB-first SPI initiator that loads the control macro's mux select word
// and captures miso in the same frame; all pin outputs come straight from flops.
module spi_ctrl_master #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_ctrl_master_if.master  bus
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic div_last;
  logic sample_now;
  logic last_bit;

  assign div_last   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  // miso is captured on the final clk cycle of the high phase, one edge before sck falls
  assign sample_now = (state_q == SHIFT_HI) && (div_cnt_q == DIV_W'(CLK_DIV - 2));
  assign last_bit   = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start) state_d = SETUP;
      SETUP:    if (div_last)  state_d = SHIFT_HI;
      SHIFT_HI: if (div_last)  state_d = last_bit ? HOLD : SHIFT_LO;
      SHIFT_LO: if (div_last)  state_d = SHIFT_HI;
      HOLD:     if (div_last)  state_d = GAP;
      GAP:      if (div_last)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    div_cnt_d = (state_q == IDLE || div_last) ? '0 : div_cnt_q + DIV_W'(1);
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_sh_d   = bus.tx_data;
          mosi_d    = bus.tx_data[FRAME_BITS-1];
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      SETUP: begin
        if (div_last) sck_d = 1'b1;
      end
      SHIFT_HI: begin
        if (sample_now) rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], bus.miso};
        if (div_last) begin
          sck_d = 1'b0;
          if (last_bit) begin
            mosi_d = 1'b0;
          end else begin
            // Next bit goes out on the falling edge so it is stable a full half-period before the rise
            tx_sh_d   = tx_sh_q << 1;
            mosi_d    = tx_sh_q[FRAME_BITS-2];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      SHIFT_LO: begin
        if (div_last) sck_d = 1'b1;
      end
      HOLD: begin
        if (div_last) begin
          ss_d      = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
        end
      end
      GAP: begin
        if (div_last) busy_d = 1'b0;
      end
      default: begin
        ss_d = 1'b1;
      end
    endcase
  end

  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss      = ss_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_ctrl_master.sv
// Directed bench: a CLK_DIV=4 instance with a mode-0 slave model, plus a CLK_DIV=2 instance.
module tb_spi_ctrl_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ctrl_master_if #(.FRAME_BITS(16)) bus_a ();
  spi_ctrl_master_if #(.FRAME_BITS(16)) bus_b ();

  spi_ctrl_master #(.CLK_DIV(4), .FRAME_BITS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  spi_ctrl_master #(.CLK_DIV(2), .FRAME_BITS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  int total = 0;
  int passed = 0;
  int failed = 0;

  // Slave models: run on the falling clk edge, well away from the DUT's active edge.
  logic [15:0] slv_word;
  logic [15:0] slv_sh = '0;
  logic [15:0] slv_rx = '0;
  int          slv_rises = 0;
  int          done_a = 0;
  logic        a_ss_prev = 1'b1;
  logic        a_sck_prev = 1'b0;
  logic [15:0] slvb_rx = '0;
  int          slvb_rises = 0;
  logic        b_ss_prev = 1'b1;
  logic        b_sck_prev = 1'b0;

  assign bus_b.miso = 1'b1;

  always @(negedge clk) begin
    if (a_ss_prev && !bus_a.ss) begin
      slv_sh     <= slv_word;
      bus_a.miso <= slv_word[15];
      slv_rx     <= '0;
      slv_rises  <= 0;
    end
    if (a_sck_prev && !bus_a.sck) begin
      slv_sh     <= slv_sh << 1;
      bus_a.miso <= slv_sh[14];
    end
    if (!a_sck_prev && bus_a.sck) begin
      slv_rx    <= {slv_rx[14:0], bus_a.mosi};
      slv_rises <= slv_rises + 1;
    end
    if (bus_a.done) done_a <= done_a + 1;
    a_ss_prev  <= bus_a.ss;
    a_sck_prev <= bus_a.sck;

    if (b_ss_prev && !bus_b.ss) begin
      slvb_rx    <= '0;
      slvb_rises <= 0;
    end
    if (!b_sck_prev && bus_b.sck) begin
      slvb_rx    <= {slvb_rx[14:0], bus_b.mosi};
      slvb_rises <= slvb_rises + 1;
    end
    b_ss_prev  <= bus_b.ss;
    b_sck_prev <= bus_b.sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each tick lands 1 time unit after a falling clk edge, i.e. after the slave model updated.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int hi_cnt;
  int elapsed;
  int done_before;

  initial begin
    bus_a.start = 1'b0; bus_a.tx_data = '0;
    bus_b.start = 1'b0; bus_b.tx_data = '0;
    slv_word = 16'h5AC3;
    tick(3);
    check("rst_ss",   32'(bus_a.ss),      32'h1);
    check("rst_sck",  32'(bus_a.sck),     32'h0);
    check("rst_busy", 32'(bus_a.busy),    32'h0);
    rst_n = 1'b1;
    tick(2);

    // Frame 1: A53C out, 5AC3 back; start/tx_data poked mid-frame must be ignored
    bus_a.tx_data = 16'hA53C; bus_a.start = 1'b1;
    tick(1);                                   // T0
    bus_a.start = 1'b0;
    check("f1_t0_ss",   32'(bus_a.ss),   32'h0);
    check("f1_t0_busy", 32'(bus_a.busy), 32'h1);
    check("f1_t0_mosi", 32'(bus_a.mosi), 32'h1);
    tick(3);
    check("f1_sck_t3", 32'(bus_a.sck), 32'h0);
    tick(1);
    check("f1_sck_t4", 32'(bus_a.sck), 32'h1);
    tick(36);                                  // T0+40
    bus_a.start = 1'b1; bus_a.tx_data = 16'hFFFF;
    tick(1);
    bus_a.start = 1'b0;
    tick(90);                                  // T0+131
    check("f1_ss_t131",   32'(bus_a.ss),   32'h0);
    check("f1_done_t131", 32'(bus_a.done), 32'h0);
    tick(1);                                   // T0+132
    check("f1_ss_t132",   32'(bus_a.ss),      32'h1);
    check("f1_done_t132", 32'(bus_a.done),    32'h1);
    check("f1_rx_data",   32'(bus_a.rx_data), 32'h5AC3);
    check("f1_slave_rx",  32'(slv_rx),        32'hA53C);
    check("f1_rises",     32'(slv_rises),     32'd16);
    tick(1);
    check("f1_done_t133", 32'(bus_a.done), 32'h0);
    tick(2);
    check("f1_busy_t135", 32'(bus_a.busy), 32'h1);
    tick(1);
    check("f1_busy_t136", 32'(bus_a.busy), 32'h0);
    tick(20);
    check("f1_rx_held",  32'(bus_a.rx_data), 32'h5AC3);
    check("f1_one_done", 32'(done_a),        32'd1);
    check("f1_idle_ss",  32'(bus_a.ss),      32'h1);

    // Frames 2/3: start held high -> back-to-back with minimum gap
    slv_word = 16'hC00F;
    bus_a.tx_data = 16'h3C5A; bus_a.start = 1'b1;
    tick(1);                                   // T0'
    check("f2_t0_busy", 32'(bus_a.busy), 32'h1);
    tick(132);                                 // T0'+132
    check("f2_done",     32'(bus_a.done),    32'h1);
    check("f2_rx_data",  32'(bus_a.rx_data), 32'hC00F);
    check("f2_slave_rx", 32'(slv_rx),        32'h3C5A);
    hi_cnt = 1;
    elapsed = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      elapsed++;
      if (bus_a.ss) hi_cnt++;
      else break;
    end
    bus_a.start = 1'b0;
    check("gap_ss_high",   32'(hi_cnt),     32'd5);
    check("next_t0_at137", 32'(elapsed),    32'd5);
    check("f3_busy",       32'(bus_a.busy), 32'h1);

    // Abort frame 3 after its 7th rising sck
    done_before = done_a;
    for (int i = 0; i < 200 && slv_rises < 7; i++) tick(1);
    check("abort_rises", 32'(slv_rises), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ss",   32'(bus_a.ss),      32'h1);
    check("arst_sck",  32'(bus_a.sck),     32'h0);
    check("arst_mosi", 32'(bus_a.mosi),    32'h0);
    check("arst_busy", 32'(bus_a.busy),    32'h0);
    check("arst_done", 32'(bus_a.done),    32'h0);
    check("arst_rx",   32'(bus_a.rx_data), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(150);
    check("abort_no_done", 32'(done_a), 32'(done_before));

    // Frame 4 after the abort: full timing with 0180
    slv_word = 16'h9669;
    bus_a.tx_data = 16'h0180; bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    check("f4_t0_ss", 32'(bus_a.ss), 32'h0);
    tick(3);
    check("f4_sck_t3", 32'(bus_a.sck), 32'h0);
    tick(1);
    check("f4_sck_t4", 32'(bus_a.sck), 32'h1);
    tick(127);
    check("f4_done_t131", 32'(bus_a.done), 32'h0);
    tick(1);
    check("f4_done_t132", 32'(bus_a.done),    32'h1);
    check("f4_slave_rx",  32'(slv_rx),        32'h0180);
    check("f4_rises",     32'(slv_rises),     32'd16);
    check("f4_rx_data",   32'(bus_a.rx_data), 32'h9669);
    tick(4);
    check("f4_busy_t136", 32'(bus_a.busy), 32'h0);

    // CLK_DIV=2 instance: 4-cycle sck period, 68-cycle frame
    bus_b.tx_data = 16'h8001; bus_b.start = 1'b1;
    tick(1);
    bus_b.start = 1'b0;
    check("b_t0_ss",   32'(bus_b.ss),   32'h0);
    check("b_t0_mosi", 32'(bus_b.mosi), 32'h1);
    tick(1);
    check("b_sck_t1", 32'(bus_b.sck), 32'h0);
    tick(1);
    check("b_sck_t2", 32'(bus_b.sck), 32'h1);
    tick(1);
    check("b_sck_t3", 32'(bus_b.sck), 32'h1);
    tick(1);
    check("b_sck_t4", 32'(bus_b.sck), 32'h0);
    check("b_mosi_b1", 32'(bus_b.mosi), 32'h0);
    tick(2);
    check("b_sck_t6", 32'(bus_b.sck), 32'h1);
    tick(59);
    check("b_done_t65", 32'(bus_b.done), 32'h0);
    tick(1);
    check("b_done_t66", 32'(bus_b.done),    32'h1);
    check("b_rx_data",  32'(bus_b.rx_data), 32'hFFFF);
    check("b_slave_rx", 32'(slvb_rx),       32'h8001);
    check("b_rises",    32'(slvb_rises),    32'd16);
    tick(1);
    check("b_busy_t67", 32'(bus_b.busy), 32'h1);
    tick(1);
    check("b_busy_t68", 32'(bus_b.busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
